// File: rtl/md_pkg.sv
// Shared definitions for the multdiv issue controller: FSM states, exception
// register/rstatus defaults and the op-kind encoding.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } md_state_t;

    localparam int unsigned MD_EXC_REG      = 30;
    localparam int unsigned MD_RSTATUS_MULT = 4;
    localparam int unsigned MD_RSTATUS_DIV  = 5;

    localparam logic KIND_MULT = 1'b0;
    localparam logic KIND_DIV  = 1'b1;

endpackage

// File: rtl/md_operand_latch.sv
// Enable-loaded register holding the issued operands, destination and op kind
// for the duration of one multdiv operation; asynchronous active-high reset.
module md_operand_latch
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd,
    input  logic             kind,
    output logic [WIDTH-1:0] lat_op_a,
    output logic [WIDTH-1:0] lat_op_b,
    output logic [4:0]       lat_rd,
    output logic             lat_kind
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_op_a <= '0;
            lat_op_b <= '0;
            lat_rd   <= '0;
            lat_kind <= KIND_MULT;
        end else if (load) begin
            lat_op_a <= op_a;
            lat_op_b <= op_b;
            lat_rd   <= rd;
            lat_kind <= kind;
        end
    end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage initiator for the multdiv unit: issues a one-cycle start pulse,
// stalls until the result is ready, then emits a one-cycle writeback packet.
// Optional watchdog in WAIT enabled by defining MD_TIMEOUT_EN.
module multdiv_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned EXC_REG        = MD_EXC_REG,
    parameter int unsigned RSTATUS_MULT   = MD_RSTATUS_MULT,
    parameter int unsigned RSTATUS_DIV    = MD_RSTATUS_DIV,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_is_mult,
    input  logic             in_is_div,
    input  logic [WIDTH-1:0] in_opA,
    input  logic [WIDTH-1:0] in_opB,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] md_operandA,
    output logic [WIDTH-1:0] md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_exception
);

    md_state_t        state, state_nxt;
    logic             trigger, load, capture, timeout_hit;
    logic [WIDTH-1:0] lat_op_a, lat_op_b;
    logic [4:0]       lat_rd;
    logic             lat_kind;
    logic [WIDTH-1:0] res_data;
    logic             res_exc;

    assign trigger = in_valid & (in_is_mult | in_is_div) & ~flush;
    assign load    = (state == IDLE) & trigger;
    assign capture = (state == WAIT) & ~flush & (md_resultRDY | timeout_hit);

    md_operand_latch #(
        .WIDTH (WIDTH)
    ) u_latch (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .op_a     (in_opA),
        .op_b     (in_opB),
        .rd       (in_rd),
        .kind     (in_is_mult ? KIND_MULT : KIND_DIV),
        .lat_op_a (lat_op_a),
        .lat_op_b (lat_op_b),
        .lat_rd   (lat_rd),
        .lat_kind (lat_kind)
    );

    assign md_operandA = lat_op_a;
    assign md_operandB = lat_op_b;

`ifdef MD_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counts cycles since START (START itself is cycle 0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (load) begin
            wait_cnt <= '0;
        end else if (state == START || state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_data <= '0;
            res_exc  <= 1'b0;
        end else if (capture) begin
            res_data <= md_result;
            res_exc  <= md_resultRDY ? md_exception : 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        wb_exception = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        stall     = 1'b1;
                        state_nxt = START;
                    end
                end
                START: begin
                    stall        = 1'b1;
                    md_ctrl_MULT = (lat_kind == KIND_MULT);
                    md_ctrl_DIV  = (lat_kind == KIND_DIV);
                    state_nxt    = WAIT;
                end
                WAIT: begin
                    stall = 1'b1;
                    if (capture) state_nxt = DONE;
                end
                DONE: begin
                    state_nxt = IDLE;
                    if (res_exc) begin
                        wb_valid     = 1'b1;
                        wb_rd        = 5'(EXC_REG);
                        wb_data      = (lat_kind == KIND_MULT) ? WIDTH'(RSTATUS_MULT)
                                                               : WIDTH'(RSTATUS_DIV);
                        wb_exception = 1'b1;
                    end else if (lat_rd != 5'd0) begin
                        wb_valid = 1'b1;
                        wb_rd    = lat_rd;
                        wb_data  = res_data;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed self-checking bench for multdiv_issue_ctrl; the multdiv side is driven
// by hand with fixed latencies and hand-computed results.
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_is_mult, in_is_div, flush;
    logic [31:0] in_opA, in_opB;
    logic [4:0]  in_rd;
    logic        stall;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    multdiv_issue_ctrl #(
        .WIDTH          (32),
        .EXC_REG        (30),
        .RSTATUS_MULT   (4),
        .RSTATUS_DIV    (5),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_is_mult   (in_is_mult),
        .in_is_div    (in_is_div),
        .in_opA       (in_opA),
        .in_opB       (in_opB),
        .in_rd        (in_rd),
        .flush        (flush),
        .stall        (stall),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Issues one op in the current (IDLE) cycle, returns one cycle after DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic is_mult, input logic is_div,
                          input int unsigned lat, input logic [31:0] res, input logic exc,
                          input logic scramble, input logic exp_valid, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data, input logic exp_exc, input logic exp_mult);
        int unsigned pulses = 0, stall_low = 0, early_wb = 0, op_bad = 0;
        in_valid = 1'b1; in_is_mult = is_mult; in_is_div = is_div;
        in_opA = a; in_opB = b; in_rd = rd;
        #1;
        check_eq({tag, "_trig_stall"}, 32'(stall), 32'd1);
        step;
        md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF;
        #1;
        check_eq({tag, "_pulse_mult"}, 32'(md_ctrl_MULT), 32'(exp_mult));
        check_eq({tag, "_pulse_div"}, 32'(md_ctrl_DIV), 32'(!exp_mult));
        check_eq({tag, "_start_stall"}, 32'(stall), 32'd1);
        check_eq({tag, "_opA"}, md_operandA, a);
        check_eq({tag, "_opB"}, md_operandB, b);
        for (int unsigned k = 1; k <= lat; k++) begin
            step;
            if (scramble) begin
                in_opA = $urandom;
                in_opB = $urandom;
            end
            md_resultRDY = (k == lat);
            md_result    = (k == lat) ? res : 32'h0BAD_0BAD;
            md_exception = (k == lat) ? exc : 1'b0;
            #1;
            if (md_ctrl_MULT || md_ctrl_DIV) pulses++;
            if (!stall) stall_low++;
            if (wb_valid) early_wb++;
            if (md_operandA !== a || md_operandB !== b) op_bad++;
        end
        step;
        md_resultRDY = 1'b0; md_exception = 1'b0; md_result = '0;
        #1;
        check_eq({tag, "_extra_pulses"}, pulses, 0);
        check_eq({tag, "_stall_low"}, stall_low, 0);
        check_eq({tag, "_early_wb"}, early_wb, 0);
        check_eq({tag, "_op_hold"}, op_bad, 0);
        check_eq({tag, "_done_stall"}, 32'(stall), 32'd0);
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq({tag, "_wb_rd"}, 32'(wb_rd), 32'(exp_rd));
            check_eq({tag, "_wb_data"}, wb_data, exp_data);
            check_eq({tag, "_wb_exc"}, 32'(wb_exception), 32'(exp_exc));
        end
        step;
        in_valid = 1'b0; in_is_mult = 1'b0; in_is_div = 1'b0;
        #1;
        check_eq({tag, "_idle_wb"}, 32'(wb_valid), 32'd0);
        check_eq({tag, "_no_reissue"}, 32'(md_ctrl_MULT | md_ctrl_DIV), 32'd0);
        check_eq({tag, "_idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned bad_wb, bad_stall, bad_pulse;
        reset = 1'b1; in_valid = 1'b0; in_is_mult = 1'b0; in_is_div = 1'b0;
        flush = 1'b0; in_opA = '0; in_opB = '0; in_rd = '0;
        md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
        #12;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        check_eq("rst_opA", md_operandA, 32'd0);
        check_eq("rst_opB", md_operandB, 32'd0);
        check_eq("rst_wb", 32'({wb_valid, wb_exception, wb_rd}), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        step;

        run_op("mul7x-3", 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 0, 33, 32'hFFFF_FFEB, 0, 0,
               1, 5'd5, 32'hFFFF_FFEB, 0, 1);
        run_op("div10/0", 32'd10, 32'd0, 5'd6, 0, 1, 34, 32'd0, 1, 0,
               1, 5'd30, 32'd5, 1, 0);
        run_op("mul_ovf", 32'h7FFF_FFFF, 32'd2, 5'd9, 1, 0, 10, 32'hFFFF_FFFE, 1, 0,
               1, 5'd30, 32'd4, 1, 1);
        run_op("mul_scramble", 32'd100, 32'd3, 5'd12, 1, 0, 8, 32'd300, 0, 1,
               1, 5'd12, 32'd300, 0, 1);
        run_op("both_kinds", 32'd6, 32'd7, 5'd3, 1, 1, 4, 32'd42, 1, 0,
               1, 5'd30, 32'd4, 1, 1);
        run_op("rd_zero", 32'd2, 32'd3, 5'd0, 1, 0, 3, 32'd6, 0, 0,
               0, 5'd0, 32'd0, 0, 1);

        // flush at WAIT cycle 10, stray ready at cycle 20
        in_valid = 1'b1; in_is_div = 1'b1; in_opA = 32'd50; in_opB = 32'd5; in_rd = 5'd4;
        step;
        for (int unsigned k = 1; k < 10; k++) step;
        step;
        flush = 1'b1; in_valid = 1'b0; in_is_div = 1'b0;
        step;
        flush = 1'b0;
        #1;
        check_eq("flush_stall", 32'(stall), 32'd0);
        bad_wb = 0; bad_stall = 0; bad_pulse = 0;
        for (int unsigned k = 12; k <= 30; k++) begin
            step;
            md_resultRDY = (k == 20);
            md_result = 32'd10;
            #1;
            if (wb_valid) bad_wb++;
            if (stall) bad_stall++;
            if (md_ctrl_MULT || md_ctrl_DIV) bad_pulse++;
        end
        md_resultRDY = 1'b0;
        check_eq("flush_no_wb", bad_wb, 0);
        check_eq("flush_no_stall", bad_stall, 0);
        check_eq("flush_no_pulse", bad_pulse, 0);

        // asynchronous reset in the middle of WAIT
        step;
        in_valid = 1'b1; in_is_mult = 1'b1; in_opA = 32'd9; in_opB = 32'd9; in_rd = 5'd8;
        step;
        for (int unsigned k = 1; k <= 5; k++) step;
        reset = 1'b1; in_valid = 1'b0; in_is_mult = 1'b0;
        #1;
        check_eq("arst_stall", 32'(stall), 32'd0);
        check_eq("arst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        check_eq("arst_wb", 32'(wb_valid), 32'd0);
        check_eq("arst_opA", md_operandA, 32'd0);
        step;
        reset = 1'b0;
        step;
        run_op("mul3x4", 32'd3, 32'd4, 5'd7, 1, 0, 5, 32'd12, 0, 0,
               1, 5'd7, 32'd12, 0, 1);

`ifdef MD_TIMEOUT_EN
        in_valid = 1'b1; in_is_div = 1'b1; in_opA = 32'd1; in_opB = 32'd0; in_rd = 5'd2;
        step;
        bad_wb = 0;
        for (int unsigned k = 1; k < 64; k++) begin
            step;
            if (wb_valid) bad_wb++;
        end
        check_eq("tmo_early_wb", bad_wb, 0);
        step;
        check_eq("tmo_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("tmo_wb_rd", 32'(wb_rd), 32'd30);
        check_eq("tmo_wb_data", wb_data, 32'd5);
        check_eq("tmo_wb_exc", 32'(wb_exception), 32'd1);
        in_valid = 1'b0; in_is_div = 1'b0;
        step;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
